// File: rtl/ahb_master_arbiter_if.sv
// +--------------------------------------------------------------------+
// | ahb_master_arbiter_if : requester handshakes plus AHB-lite master    |
// | Rev 1.0                                                              |
// +--------------------------------------------------------------------+
`default_nettype none

interface ahb_master_arbiter_if;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_gnt;
  logic        if_rvalid;
  logic        ls_req;
  logic [31:0] ls_addr;
  logic        ls_write;
  logic [1:0]  ls_size;
  logic [31:0] ls_wdata;
  logic        ls_gnt;
  logic        ls_rvalid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [31:0] haddr;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [31:0] hwdata;
  logic [31:0] hrdata;
  logic        hready;
  logic        hresp;

  // Arbiter side: serves the requesters and masters the AHB bus
  modport slave (
    input  if_req, if_addr, ls_req, ls_addr, ls_write, ls_size, ls_wdata,
    input  hrdata, hready, hresp,
    output if_gnt, if_rvalid, ls_gnt, ls_rvalid, rsp_rdata, rsp_err,
    output haddr, htrans, hwrite, hsize, hwdata
  );

  // Environment side: requesters plus the AHB slave response path
  modport master (
    output if_req, if_addr, ls_req, ls_addr, ls_write, ls_size, ls_wdata,
    output hrdata, hready, hresp,
    input  if_gnt, if_rvalid, ls_gnt, ls_rvalid, rsp_rdata, rsp_err,
    input  haddr, htrans, hwrite, hsize, hwdata
  );
endinterface

`default_nettype wire

// File: rtl/ahb_master_arbiter.sv
// +--------------------------------------------------------------------+
// | ahb_master_arbiter : shares one AHB-lite master port between fetch  |
// | and load/store, LS priority with bounded fetch starvation. Rev 1.0 |
// +--------------------------------------------------------------------+
`default_nettype none

module ahb_master_arbiter #(
  parameter int FETCH_MAX_WAIT = 4,
  parameter int WCNT_W         = 3
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  ahb_master_arbiter_if.slave   ahb_if
);

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IF   = 2'd1,
    OWN_LS   = 2'd2
  } owner_e;

  localparam logic [WCNT_W-1:0] c_wait_max  = WCNT_W'(FETCH_MAX_WAIT);
  localparam bit                c_starve_en = (FETCH_MAX_WAIT != 0);

  owner_e            owner_q, owner_d;
  logic              err_q, err_d;
  logic [WCNT_W-1:0] wcnt_q, wcnt_d;
  logic [31:0]       haddr_q, haddr_d;
  logic              hwrite_q, hwrite_d;
  logic [2:0]        hsize_q, hsize_d;
  logic [31:0]       hwdata_q, hwdata_d;

  logic w_open;
  logic w_if_pick;
  logic w_if_gnt;
  logic w_ls_gnt;

  // Reset gates arbitration so no grant can escape while rst_ni is low
  assign w_open    = rst_ni & ahb_if.hready & ~err_q;
  assign w_if_pick = ahb_if.if_req &
                     (~ahb_if.ls_req | (c_starve_en & (wcnt_q == c_wait_max)));
  assign w_if_gnt  = w_open & w_if_pick;
  assign w_ls_gnt  = w_open & ahb_if.ls_req & ~w_if_pick;

  always_comb begin
    owner_d  = owner_q;
    err_d    = err_q;
    wcnt_d   = wcnt_q;
    haddr_d  = haddr_q;
    hwrite_d = hwrite_q;
    hsize_d  = hsize_q;
    hwdata_d = hwdata_q;

    if (w_if_gnt) begin
      haddr_d  = ahb_if.if_addr;
      hwrite_d = 1'b0;
      hsize_d  = 3'b010;
    end else if (w_ls_gnt) begin
      haddr_d  = ahb_if.ls_addr;
      hwrite_d = ahb_if.ls_write;
      hsize_d  = {1'b0, ahb_if.ls_size};
      if (ahb_if.ls_write) begin
        hwdata_d = ahb_if.ls_wdata;
      end
    end

    if (ahb_if.hready) begin
      if (w_if_gnt) begin
        owner_d = OWN_IF;
      end else if (w_ls_gnt) begin
        owner_d = OWN_LS;
      end else begin
        owner_d = OWN_NONE;
      end
    end

    // Two-cycle ERROR: flag on the stalled first cycle, clear on the second
    if (ahb_if.hresp && !ahb_if.hready) begin
      err_d = 1'b1;
    end else if (ahb_if.hresp && ahb_if.hready) begin
      err_d = 1'b0;
    end

    if (w_if_gnt || !ahb_if.if_req) begin
      wcnt_d = '0;
    end else if (w_ls_gnt && (wcnt_q != c_wait_max)) begin
      wcnt_d = wcnt_q + WCNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      owner_q  <= OWN_NONE;
      err_q    <= 1'b0;
      wcnt_q   <= '0;
      haddr_q  <= '0;
      hwrite_q <= 1'b0;
      hsize_q  <= '0;
      hwdata_q <= '0;
    end else begin
      owner_q  <= owner_d;
      err_q    <= err_d;
      wcnt_q   <= wcnt_d;
      haddr_q  <= haddr_d;
      hwrite_q <= hwrite_d;
      hsize_q  <= hsize_d;
      hwdata_q <= hwdata_d;
    end
  end

  // Address-phase outputs follow the winner, otherwise hold the last value
  assign ahb_if.if_gnt    = w_if_gnt;
  assign ahb_if.ls_gnt    = w_ls_gnt;
  assign ahb_if.htrans    = (w_if_gnt | w_ls_gnt) ? 2'b10 : 2'b00;
  assign ahb_if.haddr     = haddr_d;
  assign ahb_if.hwrite    = hwrite_d;
  assign ahb_if.hsize     = hsize_d;
  assign ahb_if.hwdata    = hwdata_q;

  assign ahb_if.if_rvalid = (owner_q == OWN_IF) & ahb_if.hready;
  assign ahb_if.ls_rvalid = (owner_q == OWN_LS) & ahb_if.hready;
  assign ahb_if.rsp_rdata = ahb_if.hrdata;
  assign ahb_if.rsp_err   = ahb_if.hresp & ahb_if.hready & (owner_q != OWN_NONE);

endmodule

`default_nettype wire

// File: doc/ahb_master_arbiter.md
Name: ahb_master_arbiter

Overview:
- Shares the core's single AHB-lite master port between two requesters: instruction fetch (IF) and load/store (LS).
- Sits between the fetch unit/LSU and the external AHB-lite interface of cortex_m0.
- Arbitrates address phases, tracks data-phase ownership, steers responses back to the owner, and handles the two-cycle ERROR response.
- LS has priority; a bounded wait counter prevents fetch starvation.

Parameters:
FETCH_MAX_WAIT, 4, consecutive IF-losing cycles before IF is forced to win; 0 = strict LS priority
WCNT_W, 3, width of the starvation counter; must satisfy 2**WCNT_W > FETCH_MAX_WAIT

Ports:
clk  in  1  core clock
reset  in  1  asynchronous, active-low reset
if_req  in  1  fetch requests an address phase
if_addr  in  32  fetch address, word aligned
if_gnt  out  1  fetch address phase accepted this cycle
if_rvalid  out  1  fetch data phase completes this cycle
ls_req  in  1  load/store requests an address phase
ls_addr  in  32  load/store address
ls_write  in  1  1 = store
ls_size  in  2  0 = byte, 1 = half, 2 = word
ls_wdata  in  32  store data, valid with ls_req
ls_gnt  out  1  load/store address phase accepted this cycle
ls_rvalid  out  1  load/store data phase completes this cycle
rsp_rdata  out  32  read data, valid with if_rvalid/ls_rvalid
rsp_err  out  1  completing transfer ended in ERROR
haddr  out  32  AHB address
htrans  out  2  IDLE = 00, NONSEQ = 10 only
hwrite  out  1  AHB write
hsize  out  3  AHB size; always 010 for IF
hwdata  out  32  AHB write data, registered
hrdata  in  32  AHB read data
hready  in  1  AHB ready
hresp  in  1  AHB error response

Behaviour:
- Reset (reset = 0, asynchronous)
  - Data-phase owner = NONE, error flag = 0, wait counter = 0, hwdata = 0.
  - Forced low while reset = 0: htrans, if_gnt, ls_gnt, haddr, hwrite, hsize.
  - Zero when owner = NONE: if_rvalid, ls_rvalid, rsp_err.
- Arbitration (combinational)
  - Arbitration is open when hready = 1 and the error flag = 0.
  - IF wins if if_req = 1 and ls_req = 0, or if both are requesting and wait counter == FETCH_MAX_WAIT with FETCH_MAX_WAIT != 0.
  - Otherwise LS wins whenever ls_req = 1.
  - The winner's gnt = 1 and htrans = NONSEQ. haddr, hwrite and hsize are muxed from the winner; IF uses hwrite = 0, hsize = 010; LS uses hsize = {0, ls_size}.
  - No winner, or arbitration closed: htrans = IDLE, both gnt = 0, and haddr/hwrite/hsize hold their last driven values.
  - A requester must hold req and its fields stable until its gnt.
- Data-phase owner register (updates only when hready = 1)
  - owner <= IF if if_gnt, LS if ls_gnt, otherwise NONE.
  - On ls_gnt with ls_write = 1, hwdata <= ls_wdata; hwdata is held otherwise.
- Responses (zero-latency passthrough)
  - if_rvalid = (owner == IF) & hready; ls_rvalid = (owner == LS) & hready.
  - rsp_rdata = hrdata; rsp_err = hresp & hready & (owner != NONE).
  - hready = 0 stalls: no rvalid, no grant, owner held.
- ERROR handling
  - When hresp = 1 & hready = 0 (first error cycle), set error flag; this forces htrans = IDLE in the following cycle.
  - The flag clears on the second cycle (hresp = 1 & hready = 1). That cycle delivers rvalid + rsp_err to the owner, and arbitration stays closed: no grant issues in that cycle.
  - Normal arbitration resumes the next cycle.
- Starvation counter
  - Increments (saturating at FETCH_MAX_WAIT) each cycle where if_req = 1, ls_gnt = 1 and if_gnt = 0.
  - Clears on if_gnt or when if_req = 0.
  - Holds when arbitration is closed.
- Simultaneous events: a completing data phase and a new grant in the same hready = 1 cycle are both legal (back-to-back pipelining). The owner is replaced by the new grantee.
- Mid-operation reset: the in-flight transfer is abandoned silently; no rvalid or err is reported for it.

Test Plan:
- Only if_req = 1, if_addr = 0x100, hready = 1 each cycle -> if_gnt = 1, haddr = 0x100, htrans = 10, hsize = 010; next cycle if_rvalid = 1, rsp_rdata = hrdata.
- if_req and ls_req both held high, LS store 0x2000 word data 0xDEADBEEF, FETCH_MAX_WAIT = 4 -> ls_gnt for 4 cycles, IF wins cycle 5; hwdata = 0xDEADBEEF in the cycle after each store grant; counter returns to 0.
- ls_req read, then hready = 0 for 3 cycles in the data phase -> ls_rvalid only on the 4th cycle; no new grant while hready = 0, even with if_req = 1.
- LS data phase gets hresp = 1/hready = 0 then hresp = 1/hready = 1 -> htrans = IDLE in the cycle after the first error cycle; ls_rvalid = 1 and rsp_err = 1 in the second; pending if_req granted on the following cycle.
- Drop reset to 0 mid data phase with owner = IF -> htrans = 00 and gnt = 0 immediately; after release, no if_rvalid for the abandoned transfer; owner = NONE.
- FETCH_MAX_WAIT = 0, both requests held for 10 cycles -> ls_gnt every cycle, if_gnt never.
